// File: rtl/uart_rx_path.sv
// Receive path: synchronises and oversamples the serial input, deserialises 8N1 frames
// and queues each byte plus its framing-error flag in a show-ahead RX FIFO.
module uart_rx_path #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          uart_clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          rx_serial,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_frame_err,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_active,
  output logic                          overrun_err,
  input  logic                          err_clear,
  input  logic                          fifo_reset
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned EW = DATA_WIDTH + 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_STOP       = 3'd3;
  localparam logic [2:0] ST_BREAK_WAIT = 3'd4;

  logic                  sync1_q, rxs_q;
  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  push_req;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  overrun_q;
  logic                  do_push, do_pop, overrun_set;

  // Synchroniser resets to the idle (high) line level
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs_q) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            if (!rxs_q) begin
              state_d = ST_DATA;
              bit_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rxs_q, shift_q[DATA_WIDTH-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) state_d = ST_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            push_req = 1'b1;
            tick_d   = '0;
            state_d  = rxs_q ? ST_IDLE : ST_BREAK_WAIT;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        ST_BREAK_WAIT: begin
          if (rxs_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign rx_active = (state_q != ST_IDLE);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_pop      = rd_en && (level_q != '0);
  assign do_push     = push_req && ((level_q != LVL_FULL) || do_pop);
  assign overrun_set = push_req && (level_q == LVL_FULL) && !do_pop;

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (fifo_reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= {!rxs_q, shift_q};
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_q <= level_q + LW'(1);
        else if (!do_push && do_pop) level_q <= level_q - LW'(1);
      end
      if (overrun_set)    overrun_q <= 1'b1;
      else if (err_clear) overrun_q <= 1'b0;
    end
  end

  assign rd_data      = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign rd_frame_err = mem_q[rd_ptr_q][DATA_WIDTH];
  assign rx_level     = level_q;
  assign rx_empty     = (level_q == '0);
  assign rx_full      = (level_q == LVL_FULL);
  assign overrun_err  = overrun_q;

endmodule
